// File: rtl/uart_pkg.sv
// Shared encodings for the UART receive path:
// parity types, receiver states and checker error-flag bit positions.
package uart_pkg;

    localparam logic [1:0] PAR_NONE0 = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE1 = 2'b11;

    localparam int ERR_PARITY = 0;
    localparam int ERR_START  = 1;
    localparam int ERR_STOP   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } rx_state_e;

    function automatic logic has_parity(input logic [1:0] t);
        logic r;
        r = 1'b0;
        unique case (t)
            PAR_ODD, PAR_EVEN:   r = 1'b1;
            PAR_NONE0, PAR_NONE1: r = 1'b0;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receive output buffer: byte + error flags with
// valid/ready handshake and sticky overrun.
interface uart_rx_ctrl_if;

    logic       rx_ready;
    logic [7:0] data_out;
    logic [2:0] err_out;
    logic       rx_valid;
    logic       overrun;

    modport master (
        input  rx_ready,
        output data_out,
        output err_out,
        output rx_valid,
        output overrun
    );

    modport slave (
        output rx_ready,
        input  data_out,
        input  err_out,
        input  rx_valid,
        input  overrun
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the serial line.
// Presets to 1 so an idle line never looks like a start edge.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: frames start/data/parity/stop,
// feeds the error checker and buffers each received byte.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE        = 16,
    parameter int SYNC_STAGES       = 2,
    parameter int FALSE_START_ABORT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              baud_tick,
    input  logic              rx_in,
    input  logic [1:0]        parity_type,
    input  logic [2:0]        err_in,
    output logic [7:0]        raw_data,
    output logic              parity_bit,
    output logic              start_bit,
    output logic              stop_bit,
    output logic              frame_done,
    output logic              busy,
    uart_rx_ctrl_if.master    buf_if
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    rx_state_e state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    ptype_q, ptype_d;
    logic [7:0]    raw_q, raw_d;
    logic          par_q, par_d;
    logic          start_q, start_d;
    logic          stop_q, stop_d;
    logic [7:0]    dout_q, dout_d;
    logic [2:0]    eout_q, eout_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
    logic          rx_s;
    logic          done;
    logic          xfer;
    logic          wrap;

    uart_rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (rx_in),
        .sync_o  (rx_s)
    );

    assign done = (state_q == ST_DONE);
    assign xfer = valid_q && buf_if.rx_ready;
    assign wrap = baud_tick && (tick_q == TICK_LAST);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ptype_d = ptype_q;
        raw_d   = raw_q;
        par_d   = par_q;
        start_d = start_q;
        stop_d  = stop_q;
        dout_d  = dout_q;
        eout_d  = eout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    tick_d  = '0;
                    ptype_d = parity_type;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    if (tick_q == TICK_HALF) begin
                        if (rx_s && (FALSE_START_ABORT != 0)) begin
                            state_d = ST_IDLE;
                        end else begin
                            start_d = rx_s;
                            tick_d  = '0;
                            bit_d   = '0;
                            state_d = ST_DATA;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    tick_d = tick_q + 1'b1;
                end
                if (wrap) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        if (has_parity(ptype_q)) begin
                            state_d = ST_PARITY;
                        end else begin
                            par_d   = 1'b1;
                            state_d = ST_STOP;
                        end
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    tick_d = tick_q + 1'b1;
                end
                if (wrap) begin
                    par_d   = rx_s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    tick_d = tick_q + 1'b1;
                end
                if (wrap) begin
                    stop_d  = rx_s;
                    raw_d   = shift_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A full buffer drops the new frame unless it drains on this edge.
        if (done) begin
            if (valid_q && !buf_if.rx_ready) begin
                ovr_d = 1'b1;
            end else begin
                dout_d  = raw_q;
                eout_d  = err_in;
                valid_d = 1'b1;
                if (xfer) begin
                    ovr_d = 1'b0;
                end
            end
        end else if (xfer) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ptype_q <= PAR_NONE0;
            raw_q   <= '0;
            par_q   <= 1'b1;
            start_q <= 1'b0;
            stop_q  <= 1'b1;
            dout_q  <= '0;
            eout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ptype_q <= ptype_d;
            raw_q   <= raw_d;
            par_q   <= par_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            dout_q  <= dout_d;
            eout_q  <= eout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign raw_data        = raw_q;
    assign parity_bit      = par_q;
    assign start_bit       = start_q;
    assign stop_bit        = stop_q;
    assign frame_done      = done;
    assign busy            = (state_q != ST_IDLE);
    assign buf_if.data_out = dout_q;
    assign buf_if.err_out  = eout_q;
    assign buf_if.rx_valid = valid_q;
    assign buf_if.overrun  = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frame-level model with a queue of
// expected frames and a buffer/handshake model checked every cycle.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic [2:0] e;
        int         t0;
        int         nb;
    } frm_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx_in = 1'b1;
    logic [1:0] parity_type = 2'b00;
    logic [2:0] err_in;
    logic [7:0] raw_data;
    logic       parity_bit, start_bit, stop_bit;
    logic       frame_done, busy;
    logic [1:0] cur_pt = 2'b00;

    uart_rx_ctrl_if bif ();

    uart_rx_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .baud_tick   (baud_tick),
        .rx_in       (rx_in),
        .parity_type (parity_type),
        .err_in      (err_in),
        .raw_data    (raw_data),
        .parity_bit  (parity_bit),
        .start_bit   (start_bit),
        .stop_bit    (stop_bit),
        .frame_done  (frame_done),
        .busy        (busy),
        .buf_if      (bif)
    );

    int   nchk = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   nframes = 0;
    frm_t q[$];

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // 4 clocks per baud tick -> 64 clocks per bit
    initial forever begin
        repeat (3) @(posedge clk);
        #1 baud_tick = 1'b1;
        @(posedge clk);
        #1 baud_tick = 1'b0;
    end

    // stand-in for the external error checker
    always_comb begin
        err_in = 3'b000;
        if (frame_done) begin
            err_in[ERR_STOP]  = ~stop_bit;
            err_in[ERR_START] = start_bit;
            if (cur_pt == PAR_ODD)
                err_in[ERR_PARITY] = ~(^raw_data ^ parity_bit);
            else if (cur_pt == PAR_EVEN)
                err_in[ERR_PARITY] = ^raw_data ^ parity_bit;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] pt,
                        input logic stop_v, input logic pflip,
                        input logic chg_pt);
        frm_t f;
        logic p;
        logic pe;
        pe = (pt == PAR_ODD) || (pt == PAR_EVEN);
        p = (pt == PAR_ODD) ? ~^d : ^d;
        p = pe ? (p ^ pflip) : 1'b1;
        parity_type = pt;
        cur_pt = pt;
        f.d = d;
        f.p = p;
        f.s = stop_v;
        f.e = {~stop_v, 1'b0, pe & pflip};
        f.t0 = cyc;
        f.nb = pe ? 11 : 10;
        q.push_back(f);
        rx_in = 1'b0;
        hold(64);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            if (chg_pt && i == 3) parity_type = PAR_NONE0;
            hold(64);
        end
        if (pe) begin
            rx_in = p;
            hold(64);
        end
        rx_in = stop_v;
        hold(stop_v ? 64 : 40);
        rx_in = 1'b1;
        hold(88);
    endtask

    task automatic consume();
        bif.rx_ready = 1'b1;
        hold(1);
        bif.rx_ready = 1'b0;
        hold(1);
        chk("consume_valid", 32'(bif.rx_valid), 0);
    endtask

    // per-cycle compare against frame queue and buffer model
    initial begin
        logic       m_valid, m_ovr, pend_v, rdy_prev, fd_prev, xf;
        logic [7:0] m_data;
        logic [2:0] m_err;
        frm_t       pend, f;
        int         dt, base;
        m_valid = 0; m_ovr = 0; pend_v = 0; rdy_prev = 0; fd_prev = 0;
        m_data = 0; m_err = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_valid = 0; m_ovr = 0; pend_v = 0;
                rdy_prev = 0; fd_prev = 0;
                chk("rst_valid", 32'(bif.rx_valid), 0);
                chk("rst_ovr", 32'(bif.overrun), 0);
                chk("rst_fd", 32'(frame_done), 0);
                chk("rst_busy", 32'(busy), 0);
            end else begin
                xf = m_valid && rdy_prev;
                if (pend_v) begin
                    if (m_valid && !rdy_prev) begin
                        m_ovr = 1'b1;
                    end else begin
                        m_data = pend.d;
                        m_err = pend.e;
                        m_valid = 1'b1;
                        if (xf) m_ovr = 1'b0;
                    end
                end else if (xf) begin
                    m_valid = 1'b0;
                    m_ovr = 1'b0;
                end
                pend_v = 1'b0;
                chk("rx_valid", 32'(bif.rx_valid), 32'(m_valid));
                chk("overrun", 32'(bif.overrun), 32'(m_ovr));
                if (m_valid) begin
                    chk("data_out", 32'(bif.data_out), 32'(m_data));
                    chk("err_out", 32'(bif.err_out), 32'(m_err));
                end
                if (frame_done) begin
                    chk("fd_pulse", 32'(fd_prev), 0);
                    chk("fd_expected", 32'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        f = q.pop_front();
                        nframes++;
                        chk("raw_data", 32'(raw_data), 32'(f.d));
                        chk("parity_bit", 32'(parity_bit), 32'(f.p));
                        chk("start_bit", 32'(start_bit), 0);
                        chk("stop_bit", 32'(stop_bit), 32'(f.s));
                        dt = cyc - f.t0;
                        base = 64 * (f.nb - 1);
                        chk("fd_time", 32'(dt >= base + 31 && dt <= base + 36), 1);
                        pend = f;
                        pend_v = 1'b1;
                    end
                end
                fd_prev = frame_done;
                rdy_prev = bif.rx_ready;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bif.rx_ready = 1'b0;
        hold(5);
        chk("rst_parity_bit", 32'(parity_bit), 1);
        chk("rst_stop_bit", 32'(stop_bit), 1);
        chk("rst_start_bit", 32'(start_bit), 0);
        chk("rst_raw", 32'(raw_data), 0);
        chk("rst_dout", 32'(bif.data_out), 0);
        reset = 1'b0;
        hold(40);

        // 1: 0x5A odd parity, parity_type changed mid-frame
        send(8'h5A, PAR_ODD, 1'b1, 1'b0, 1'b1);
        chk("t1_raw", 32'(raw_data), 32'h5A);
        chk("t1_par", 32'(parity_bit), 1);
        chk("t1_dout", 32'(bif.data_out), 32'h5A);
        chk("t1_err", 32'(bif.err_out), 0);
        chk("t1_valid", 32'(bif.rx_valid), 1);
        consume();

        // bad even parity on 0x0F
        send(8'h0F, PAR_EVEN, 1'b1, 1'b1, 1'b0);
        chk("t1b_par", 32'(parity_bit), 1);
        chk("t1b_err", 32'(bif.err_out), 32'h1);
        consume();

        // 2: no parity, both encodings
        send(8'hA5, PAR_NONE0, 1'b1, 1'b0, 1'b0);
        chk("t2_dout", 32'(bif.data_out), 32'hA5);
        chk("t2_par", 32'(parity_bit), 1);
        chk("t2_err", 32'(bif.err_out), 0);
        consume();
        send(8'hC3, PAR_NONE1, 1'b1, 1'b0, 1'b0);
        chk("t2b_dout", 32'(bif.data_out), 32'hC3);
        consume();

        // 3: stop bit low
        send(8'h3C, PAR_NONE0, 1'b0, 1'b0, 1'b0);
        chk("t3_stop", 32'(stop_bit), 0);
        chk("t3_err", 32'(bif.err_out), 32'h4);
        chk("t3_valid", 32'(bif.rx_valid), 1);
        chk("t3_dout", 32'(bif.data_out), 32'h3C);
        consume();
        hold(64);

        // 4: false start
        rx_in = 1'b0;
        hold(10);
        chk("t4_busy_hi", 32'(busy), 1);
        hold(6);
        rx_in = 1'b1;
        hold(64);
        chk("t4_busy_lo", 32'(busy), 0);
        chk("t4_frames", 32'(nframes), 5);

        // 5: overrun
        send(8'h11, PAR_NONE0, 1'b1, 1'b0, 1'b0);
        send(8'h22, PAR_ODD, 1'b1, 1'b0, 1'b0);
        chk("t5_dout", 32'(bif.data_out), 32'h11);
        chk("t5_ovr", 32'(bif.overrun), 1);
        chk("t5_valid", 32'(bif.rx_valid), 1);
        bif.rx_ready = 1'b1;
        hold(2);
        chk("t5_valid_lo", 32'(bif.rx_valid), 0);
        chk("t5_ovr_lo", 32'(bif.overrun), 0);
        bif.rx_ready = 1'b0;
        hold(4);

        // 6: reset mid-DATA of 0xFF
        rx_in = 1'b0;
        hold(64);
        rx_in = 1'b1;
        hold(64 * 3 + 10);
        chk("t6_busy_pre", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_fd", 32'(frame_done), 0);
        chk("t6_par", 32'(parity_bit), 1);
        chk("t6_raw", 32'(raw_data), 0);
        hold(3);
        reset = 1'b0;
        hold(64 * 8);
        send(8'h81, PAR_EVEN, 1'b1, 1'b0, 1'b0);
        chk("t6_dout", 32'(bif.data_out), 32'h81);
        chk("t6_err", 32'(bif.err_out), 0);
        consume();

        chk("q_empty", 32'(q.size()), 0);
        chk("frames", 32'(nframes), 8);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
